dmem_write_scoreboard: RTL and testbench

Parametrised run-time checker for the MIPS system bench. It holds a programmable table of expected data-memory writes (address -> data) and compares every dmem write of the running program against that table. It also counts cycles, detects the halt instruction, checks the ALU result at a programmed cycle, and enforces a timeout. It reports pass/fail and diagnostic counters so system benches need no hand-coded case lists.

---
 rtl/dmem_write_scoreboard.sv | 212 +++++++++++++++++++++
 tb/tb_dmem_write_scoreboard.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_write_scoreboard.sv
// Run-time checker for the MIPS system bench. It holds a programmable table of
// expected dmem writes, checks every write of the running program against it,
// counts RUN cycles, watches for the halt instruction, checks the ALU result at
// a programmed cycle and gives up after a fixed cycle budget.
module dmem_write_scoreboard #(
    parameter int                ADDR_W         = 10,
    parameter int                DATA_W         = 32,
    parameter int                DEPTH          = 8,
    parameter int                CNT_W          = 16,
    parameter logic [DATA_W-1:0] HALT_INSTR     = 32'h0800_0015,
    parameter int                TIMEOUT_CYCLES = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic                       cfg_clr,
    input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [DATA_W-1:0]          cfg_data,
    input  logic [CNT_W-1:0]           final_cycle,
    input  logic [DATA_W-1:0]          final_value,
    input  logic                       start,
    input  logic                       dmem_we,
    input  logic [DATA_W-1:0]          alu_out,
    input  logic [DATA_W-1:0]          dmem_wd,
    input  logic [DATA_W-1:0]          instruction,
    output logic [1:0]                 state,
    output logic                       pass,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [CNT_W-1:0]           match_count,
    output logic [CNT_W-1:0]           mismatch_count,
    output logic [CNT_W-1:0]           unmatched_count,
    output logic [DEPTH-1:0]           seen,
    output logic [$clog2(DEPTH)-1:0]   first_fail_idx,
    output logic [DATA_W-1:0]          first_fail_data,
    output logic                       final_ok
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t                state_r, state_next_s;
    logic [ADDR_W-1:0]     tbl_addr_r [DEPTH];
    logic [DATA_W-1:0]     tbl_data_r [DEPTH];
    logic [DEPTH-1:0]      tbl_valid_r;
    logic                  pass_r, final_ok_r, final_checked_r, fail_captured_r;
    logic [CNT_W-1:0]      cycle_count_r, match_count_r, mismatch_count_r, unmatched_count_r;
    logic [DEPTH-1:0]      seen_r;
    logic [IDX_W-1:0]      first_fail_idx_r;
    logic [DATA_W-1:0]     first_fail_data_r;

    logic [DEPTH-1:0]      match_s;
    logic                  hit_s;
    logic [IDX_W-1:0]      hit_idx_s;
    logic                  halt_s;
    logic                  last_cycle_s;
    logic                  pass_s;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign halt_s       = (instruction == HALT_INSTR);
    assign last_cycle_s = (cycle_count_r == TIMEOUT_LAST);
    assign pass_s       = (mismatch_count_r == {CNT_W{1'b0}}) && final_checked_r && final_ok_r
                          && ((seen_r & tbl_valid_r) == tbl_valid_r);

    // Address lookup: the lowest-index valid entry with a matching address wins.
    always_comb begin
        match_s   = '0;
        hit_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_s[i] = tbl_valid_r[i] && (tbl_addr_r[i] == alu_out[ADDR_W-1:0]);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit_idx_s = match_s[i] ? IDX_W'(i) : hit_idx_s;
        end
        hit_s = |match_s;
    end

    // Next-state logic of the run controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (halt_s)            state_next_s = ST_DONE;
                else if (last_cycle_s) state_next_s = ST_TIMEOUT;
                else                   state_next_s = ST_RUN;
            end
            ST_DONE, ST_TIMEOUT: begin
                if (!start) state_next_s = ST_IDLE;
                else        state_next_s = state_r;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= ST_IDLE;
        else        state_r <= state_next_s;
    end

    // Expectation table, counters, first-failure capture and verdict.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_addr_r[i] <= '0;
                tbl_data_r[i] <= '0;
            end
            tbl_valid_r       <= '0;
            pass_r            <= 1'b0;
            final_ok_r        <= 1'b0;
            final_checked_r   <= 1'b0;
            fail_captured_r   <= 1'b0;
            cycle_count_r     <= '0;
            match_count_r     <= '0;
            mismatch_count_r  <= '0;
            unmatched_count_r <= '0;
            seen_r            <= '0;
            first_fail_idx_r  <= '0;
            first_fail_data_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cfg_clr) begin
                        tbl_valid_r <= '0;
                    end else if (cfg_we) begin
                        tbl_addr_r[cfg_idx]  <= cfg_addr;
                        tbl_data_r[cfg_idx]  <= cfg_data;
                        tbl_valid_r[cfg_idx] <= 1'b1;
                    end
                    if (start) begin
                        pass_r            <= 1'b0;
                        final_ok_r        <= 1'b0;
                        final_checked_r   <= 1'b0;
                        fail_captured_r   <= 1'b0;
                        cycle_count_r     <= '0;
                        match_count_r     <= '0;
                        mismatch_count_r  <= '0;
                        unmatched_count_r <= '0;
                        seen_r            <= '0;
                        first_fail_idx_r  <= '0;
                        first_fail_data_r <= '0;
                    end
                end
                ST_RUN: begin
                    if (halt_s) begin
                        // The halt cycle carries no write check and no count.
                        pass_r <= pass_s;
                    end else begin
                        if (dmem_we) begin
                            if (!hit_s) begin
                                unmatched_count_r <= sat_inc(unmatched_count_r);
                            end else if (dmem_wd == tbl_data_r[hit_idx_s]) begin
                                match_count_r     <= sat_inc(match_count_r);
                                seen_r[hit_idx_s] <= 1'b1;
                            end else begin
                                mismatch_count_r <= sat_inc(mismatch_count_r);
                                if (!fail_captured_r) begin
                                    fail_captured_r   <= 1'b1;
                                    first_fail_idx_r  <= hit_idx_s;
                                    first_fail_data_r <= dmem_wd;
                                end
                            end
                        end
                        if (!final_checked_r && (cycle_count_r == final_cycle)) begin
                            final_checked_r <= 1'b1;
                            final_ok_r      <= (alu_out == final_value);
                        end
                        if (last_cycle_s) begin
                            pass_r <= 1'b0;
                        end else begin
                            cycle_count_r <= sat_inc(cycle_count_r);
                        end
                    end
                end
                default: begin
                    // DONE / TIMEOUT: everything holds until start drops.
                end
            endcase
        end
    end

    assign state           = state_r;
    assign pass            = pass_r;
    assign cycle_count     = cycle_count_r;
    assign match_count     = match_count_r;
    assign mismatch_count  = mismatch_count_r;
    assign unmatched_count = unmatched_count_r;
    assign seen            = seen_r;
    assign first_fail_idx  = first_fail_idx_r;
    assign first_fail_data = first_fail_data_r;
    assign final_ok        = final_ok_r;

endmodule

// File: tb/tb_dmem_write_scoreboard.sv
// Directed bench for dmem_write_scoreboard: each run pushes its expected end
// status into a queue and a negedge monitor compares it when the DUT enters
// DONE or TIMEOUT.
module tb_dmem_write_scoreboard;

    localparam logic [31:0] HALT = 32'h0800_0015;

    logic        clock;
    logic        reset;
    logic        cfg_we, cfg_clr;
    logic [2:0]  cfg_idx;
    logic [9:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [15:0] final_cycle;
    logic [31:0] final_value;
    logic        start, dmem_we;
    logic [31:0] alu_out, dmem_wd, instruction;
    logic [1:0]  state;
    logic        pass;
    logic [15:0] cycle_count, match_count, mismatch_count, unmatched_count;
    logic [7:0]  seen;
    logic [2:0]  first_fail_idx;
    logic [31:0] first_fail_data;
    logic        final_ok;

    typedef struct {
        logic [1:0]  st;
        logic        ps;
        logic [15:0] cc, mc, mm, um;
        logic [7:0]  sn;
        logic [2:0]  ffi;
        logic [31:0] ffd;
        logic        fok;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [1:0] prev_state = 2'd0;

    logic [9:0]  addr_tab [8] = '{10'h1FC, 10'h1F8, 10'h1F4, 10'h1F0, 10'h1EC, 10'h1E8, 10'h1E4, 10'h1E0};
    logic [31:0] data_tab [8] = '{32'h4, 32'h8, 32'h3, 32'h3C, 32'h2, 32'h3C, 32'h1, 32'h3C};

    dmem_write_scoreboard dut (
        .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_clr(cfg_clr),
        .cfg_idx(cfg_idx), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .final_cycle(final_cycle), .final_value(final_value), .start(start),
        .dmem_we(dmem_we), .alu_out(alu_out), .dmem_wd(dmem_wd),
        .instruction(instruction), .state(state), .pass(pass),
        .cycle_count(cycle_count), .match_count(match_count),
        .mismatch_count(mismatch_count), .unmatched_count(unmatched_count),
        .seen(seen), .first_fail_idx(first_fail_idx),
        .first_fail_data(first_fail_data), .final_ok(final_ok)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] st, input logic ps, input int cc, input int mc,
                            input int mm, input int um, input logic [7:0] sn,
                            input logic [2:0] ffi, input logic [31:0] ffd, input logic fok);
        exp_t e;
        e.st = st; e.ps = ps; e.cc = 16'(cc); e.mc = 16'(mc); e.mm = 16'(mm);
        e.um = 16'(um); e.sn = sn; e.ffi = ffi; e.ffd = ffd; e.fok = fok;
        exp_q.push_back(e);
    endtask

    // Monitor: compare end-of-run status whenever the DUT enters DONE or TIMEOUT.
    always @(negedge clock) begin
        exp_t e;
        if (reset && (state != prev_state) && (state == 2'd2 || state == 2'd3)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_end: state %0d with no expectation queued", state);
            end else begin
                e = exp_q.pop_front();
                chk("end_state", 32'(state), 32'(e.st));
                chk("pass", 32'(pass), 32'(e.ps));
                chk("cycle_count", 32'(cycle_count), 32'(e.cc));
                chk("match_count", 32'(match_count), 32'(e.mc));
                chk("mismatch_count", 32'(mismatch_count), 32'(e.mm));
                chk("unmatched_count", 32'(unmatched_count), 32'(e.um));
                chk("seen", 32'(seen), 32'(e.sn));
                chk("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
                chk("first_fail_data", first_fail_data, e.ffd);
                chk("final_ok", 32'(final_ok), 32'(e.fok));
            end
        end
        prev_state <= state;
    end

    task automatic clear_inputs();
        cfg_we = 1'b0; cfg_clr = 1'b0; cfg_idx = 3'd0; cfg_addr = 10'd0; cfg_data = 32'd0;
        dmem_we = 1'b0; alu_out = 32'd0; dmem_wd = 32'd0; instruction = 32'd0;
    endtask

    // Drive program cycle k (k = RUN cycle index seen by the DUT).
    task automatic drive_cycle(input int k, input int halt_at, input bit bad_1f4, input bit omit_1e0,
                               input bit extra_100, input bit halt_bad_wr, input bit cfg_pulse);
        int j;
        clear_inputs();
        if (k >= 10 && k <= 80 && (k % 10) == 0) begin
            j = k / 10 - 1;
            if (!(omit_1e0 && j == 7)) begin
                dmem_we = 1'b1;
                alu_out = {22'd0, addr_tab[j]};
                dmem_wd = (bad_1f4 && j == 2) ? 32'd5 : data_tab[j];
            end
        end
        if (extra_100 && k == 90) begin
            dmem_we = 1'b1; alu_out = 32'h100; dmem_wd = 32'h55;
        end
        if (k == 106) alu_out = 32'h18;
        if (cfg_pulse && k == 5) begin
            cfg_we = 1'b1; cfg_idx = 3'd0; cfg_addr = 10'h1FC; cfg_data = 32'd77;
        end
        if (k == halt_at) begin
            instruction = HALT;
            if (halt_bad_wr) begin
                dmem_we = 1'b1; alu_out = 32'h1FC; dmem_wd = 32'd99;
            end
        end
    endtask

    task automatic do_run(input int halt_at, input bit bad_1f4, input bit omit_1e0, input bit extra_100,
                          input bit halt_bad_wr, input bit cfg_pulse, input int budget);
        int  k;
        bit  finished;
        start = 1'b1;
        @(posedge clock); #1;
        k = 0;
        finished = 1'b0;
        while (!finished && k < budget) begin
            drive_cycle(k, halt_at, bad_1f4, omit_1e0, extra_100, halt_bad_wr, cfg_pulse);
            @(posedge clock); #1;
            if (state == 2'd2 || state == 2'd3) finished = 1'b1;
            k++;
        end
        clear_inputs();
        chk("run_terminated", 32'(finished), 32'd1);
        @(negedge clock);
        start = 1'b0;
        @(posedge clock); #1;
        chk("back_to_idle", 32'(state), 32'd0);
    endtask

    initial begin
        clear_inputs();
        start = 1'b0;
        final_cycle = 16'd106;
        final_value = 32'h18;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_counts", 32'(cycle_count | match_count | mismatch_count | unmatched_count), 32'd0);
        chk("rst_seen", 32'(seen), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            cfg_we = 1'b1; cfg_idx = 3'(i); cfg_addr = addr_tab[i]; cfg_data = data_tab[i];
        end
        @(negedge clock);
        clear_inputs();

        // Clean run.
        push_exp(2'd2, 1'b1, 110, 8, 0, 0, 8'hFF, 3'd0, 32'd0, 1'b1);
        do_run(110, 0, 0, 0, 0, 0, 200);
        chk("idle_holds_match", 32'(match_count), 32'd8);

        // Wrong data to 0x1F4.
        push_exp(2'd2, 1'b0, 110, 7, 1, 0, 8'hFB, 3'd2, 32'd5, 1'b1);
        do_run(110, 1, 0, 0, 0, 0, 200);

        // 0x1E0 never written, stray write to 0x100.
        push_exp(2'd2, 1'b0, 110, 7, 0, 1, 8'h7F, 3'd0, 32'd0, 1'b1);
        do_run(110, 0, 1, 1, 0, 0, 200);

        // Stray write alone does not spoil pass.
        push_exp(2'd2, 1'b1, 110, 8, 0, 1, 8'hFF, 3'd0, 32'd0, 1'b1);
        do_run(110, 0, 0, 1, 0, 0, 200);

        // No halt: timeout after 1024 RUN cycles.
        push_exp(2'd3, 1'b0, 1023, 8, 0, 0, 8'hFF, 3'd0, 32'd0, 1'b1);
        do_run(-1, 0, 0, 0, 0, 0, 1100);

        // Bad write in the halt cycle is ignored; cfg_we during RUN is ignored.
        push_exp(2'd2, 1'b1, 110, 8, 0, 0, 8'hFF, 3'd0, 32'd0, 1'b1);
        do_run(110, 0, 0, 0, 1, 1, 200);

        // Reset pulsed mid-run.
        start = 1'b1;
        @(posedge clock); #1;
        for (int k = 0; k < 50; k++) begin
            drive_cycle(k, -1, 0, 0, 0, 0, 0);
            @(posedge clock); #1;
        end
        clear_inputs();
        chk("mid_run_state", 32'(state), 32'd1);
        #2;
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_cycle", 32'(cycle_count), 32'd0);
        chk("async_rst_match", 32'(match_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Empty table, correct final value -> pass.
        push_exp(2'd2, 1'b1, 110, 0, 0, 8, 8'h00, 3'd0, 32'd0, 1'b1);
        do_run(110, 0, 0, 0, 0, 0, 200);

        repeat (2) @(posedge clock);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
